bip_control_unit: RTL and testbench

//  Multi-cycle control unit for the BIP processor: successor to the single-cycle combinational opcode decoder.

---
 rtl/bip_pkg.sv | 39 +++
 rtl/bip_opcode_decode.sv | 66 ++++++
 rtl/bip_control_unit.sv | 151 +++++++++++++++
 tb/tb_bip_control_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// BIP control unit shared definitions: opcode values, accumulator mux codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bip_pkg;

    // Opcode map
    localparam int unsigned OP_HLT  = 0;
    localparam int unsigned OP_STO  = 1;
    localparam int unsigned OP_LD   = 2;
    localparam int unsigned OP_LDI  = 3;
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_ADDI = 5;
    localparam int unsigned OP_SUB  = 6;
    localparam int unsigned OP_SUBI = 7;
    localparam int unsigned OP_BEQ  = 8;
    localparam int unsigned OP_BNE  = 9;
    localparam int unsigned OP_JMP  = 10;

    // Accumulator input mux selections
    localparam int unsigned SELA_DM  = 0;
    localparam int unsigned SELA_IMM = 1;
    localparam int unsigned SELA_ALU = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_EQ     = 2'd1,
        BR_NE     = 2'd2,
        BR_ALWAYS = 2'd3
    } br_kind_e;

endpackage

// File: rtl/bip_opcode_decode.sv
// Combinational opcode decoder: instruction register -> datapath controls and instruction class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs are gated by the control FSM.
// Ports: ir_i (latched opcode) in; sel_a/sel_b/op/wr_acc/mem_rd/mem_wr, branch kind, halt and illegal flags out.
module bip_opcode_decode
    import bip_pkg::*;
#(
    parameter int LEN_OPCODE = 5,
    parameter int LEN_MUX_A  = 2
) (
    input  logic [LEN_OPCODE-1:0] ir_i,
    output logic [LEN_MUX_A-1:0]  sel_a_o,
    output logic                  sel_b_o,
    output logic                  op_o,
    output logic                  wr_acc_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic                  is_branch_o,
    output logic                  is_halt_o,
    output logic                  illegal_o,
    output br_kind_e              br_kind_o
);

    always_comb begin
        sel_a_o     = LEN_MUX_A'(SELA_DM);
        sel_b_o     = 1'b0;
        op_o        = 1'b0;
        wr_acc_o    = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        is_halt_o   = 1'b0;
        illegal_o   = 1'b0;
        br_kind_o   = BR_NONE;
        case (32'(ir_i))
            OP_HLT:  is_halt_o = 1'b1;
            OP_STO:  mem_wr_o  = 1'b1;
            OP_LD: begin
                sel_a_o  = LEN_MUX_A'(SELA_DM);
                wr_acc_o = 1'b1;
                mem_rd_o = 1'b1;
            end
            OP_LDI: begin
                sel_a_o  = LEN_MUX_A'(SELA_IMM);
                wr_acc_o = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                sel_a_o  = LEN_MUX_A'(SELA_ALU);
                op_o     = (32'(ir_i) == OP_SUB);
                wr_acc_o = 1'b1;
                mem_rd_o = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                sel_a_o  = LEN_MUX_A'(SELA_ALU);
                sel_b_o  = 1'b1;
                op_o     = (32'(ir_i) == OP_SUBI);
                wr_acc_o = 1'b1;
            end
            OP_BEQ:  br_kind_o = BR_EQ;
            OP_BNE:  br_kind_o = BR_NE;
            OP_JMP:  br_kind_o = BR_ALWAYS;
            default: illegal_o = 1'b1;
        endcase
        is_branch_o = (br_kind_o != BR_NONE);
    end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: IR latch, FETCH/EXEC/WAIT/HALT sequencing, retired-instruction counter.
// Latency: 2 cycles per instruction (FETCH+EXEC) plus one cycle per data-memory wait cycle.
// Backpressure: memory ops stall in WAIT, holding RAM requests and mux selects, until RamAck_i.
// Ports: Clk_i/Reset_i (sync, active-high), Start_i, Opcode_i, Zero_i, RamAck_i in; datapath controls,
//        Halted_o, IllegalOp_o and InstrCount_o out.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int LEN_OPCODE    = 5,
    parameter int LEN_MUX_A     = 2,
    parameter int LEN_CNT       = 16,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  Start_i,
    input  logic [LEN_OPCODE-1:0] Opcode_i,
    input  logic                  Zero_i,
    input  logic                  RamAck_i,
    output logic                  WrIR_o,
    output logic                  WrPC_o,
    output logic                  SelPC_o,
    output logic [LEN_MUX_A-1:0]  SelA_o,
    output logic                  SelB_o,
    output logic                  WrAcc_o,
    output logic                  Op_o,
    output logic                  WrRam_o,
    output logic                  RdRam_o,
    output logic                  Halted_o,
    output logic                  IllegalOp_o,
    output logic [LEN_CNT-1:0]    InstrCount_o
);

    state_e                state_q, state_d;
    logic [LEN_OPCODE-1:0] ir_q, ir_d;
    logic [LEN_CNT-1:0]    cnt_q, cnt_d;
    logic                  retire;
    logic                  taken;
    logic                  ram_ack;

    logic [LEN_MUX_A-1:0]  dec_sel_a;
    logic                  dec_sel_b, dec_op, dec_wr_acc, dec_mem_rd, dec_mem_wr;
    logic                  dec_branch, dec_halt, dec_illegal;
    br_kind_e              dec_br_kind;

    bip_opcode_decode #(
        .LEN_OPCODE (LEN_OPCODE),
        .LEN_MUX_A  (LEN_MUX_A)
    ) u_decode (
        .ir_i        (ir_q),
        .sel_a_o     (dec_sel_a),
        .sel_b_o     (dec_sel_b),
        .op_o        (dec_op),
        .wr_acc_o    (dec_wr_acc),
        .mem_rd_o    (dec_mem_rd),
        .mem_wr_o    (dec_mem_wr),
        .is_branch_o (dec_branch),
        .is_halt_o   (dec_halt),
        .illegal_o   (dec_illegal),
        .br_kind_o   (dec_br_kind)
    );

    // Without the handshake every memory access is assumed to complete in EXEC.
    assign ram_ack      = (MEM_HANDSHAKE != 0) ? RamAck_i : 1'b1;
    assign InstrCount_o = cnt_q;

    always_comb begin
        taken = 1'b0;
        case (dec_br_kind)
            BR_EQ:     taken = Zero_i;
            BR_NE:     taken = !Zero_i;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        retire      = 1'b0;
        WrIR_o      = 1'b0;
        WrPC_o      = 1'b0;
        SelPC_o     = 1'b0;
        SelA_o      = '0;
        SelB_o      = 1'b0;
        WrAcc_o     = 1'b0;
        Op_o        = 1'b0;
        WrRam_o     = 1'b0;
        RdRam_o     = 1'b0;
        Halted_o    = 1'b0;
        IllegalOp_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                WrIR_o  = 1'b1;
                ir_d    = Opcode_i;
                state_d = ST_EXEC;
            end
            ST_EXEC, ST_WAIT: begin
                // Selects and RAM requests stay asserted across the whole stall.
                SelA_o  = dec_sel_a;
                SelB_o  = dec_sel_b;
                Op_o    = dec_op;
                RdRam_o = dec_mem_rd;
                WrRam_o = dec_mem_wr;
                if (state_q == ST_EXEC) begin
                    IllegalOp_o = dec_illegal;
                    if (dec_halt) begin
                        state_d = ST_HALT;
                    end else if ((dec_mem_rd || dec_mem_wr) && !ram_ack) begin
                        state_d = ST_WAIT;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (ram_ack) begin
                    retire = 1'b1;
                end
            end
            ST_HALT: begin
                Halted_o = 1'b1;
                if (Start_i) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
            state_d = ST_FETCH;
            WrPC_o  = 1'b1;
            WrAcc_o = dec_wr_acc;
            SelPC_o = dec_branch && taken;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + LEN_CNT'(1);
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: directed scenarios then randomized instruction stream.
// Latency: n/a.
// Backpressure: RamAck stalls are generated by the bench per instruction.
module tb_bip_control_unit;

    logic       Clk = 1'b0;
    logic       Reset, Start, Zero, RamAck;
    logic [4:0] Opcode;

    logic        WrIR, WrPC, SelPC, SelB, WrAcc, Op, WrRam, RdRam, Halted, IllegalOp;
    logic [1:0]  SelA;
    logic [15:0] InstrCount;

    logic        s_WrIR, s_WrPC, s_SelPC, s_SelB, s_WrAcc, s_Op, s_WrRam, s_RdRam, s_Halted, s_IllegalOp;
    logic [1:0]  s_SelA;
    logic [1:0]  s_InstrCount;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned retired  = 0;

    always #5 Clk = ~Clk;

    bip_control_unit #(.LEN_OPCODE(5), .LEN_MUX_A(2), .LEN_CNT(16), .MEM_HANDSHAKE(1)) dut (
        .Clk_i(Clk), .Reset_i(Reset), .Start_i(Start), .Opcode_i(Opcode), .Zero_i(Zero),
        .RamAck_i(RamAck), .WrIR_o(WrIR), .WrPC_o(WrPC), .SelPC_o(SelPC), .SelA_o(SelA),
        .SelB_o(SelB), .WrAcc_o(WrAcc), .Op_o(Op), .WrRam_o(WrRam), .RdRam_o(RdRam),
        .Halted_o(Halted), .IllegalOp_o(IllegalOp), .InstrCount_o(InstrCount)
    );

    // Narrow-counter instance to exercise saturation.
    bip_control_unit #(.LEN_OPCODE(5), .LEN_MUX_A(2), .LEN_CNT(2), .MEM_HANDSHAKE(1)) dut_sat (
        .Clk_i(Clk), .Reset_i(Reset), .Start_i(Start), .Opcode_i(Opcode), .Zero_i(Zero),
        .RamAck_i(RamAck), .WrIR_o(s_WrIR), .WrPC_o(s_WrPC), .SelPC_o(s_SelPC), .SelA_o(s_SelA),
        .SelB_o(s_SelB), .WrAcc_o(s_WrAcc), .Op_o(s_Op), .WrRam_o(s_WrRam), .RdRam_o(s_RdRam),
        .Halted_o(s_Halted), .IllegalOp_o(s_IllegalOp), .InstrCount_o(s_InstrCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: instruction properties taken straight from the ISA table.
    function automatic bit m_mem(input int unsigned op);  return op inside {1, 2, 4, 6}; endfunction
    function automatic bit m_rd(input int unsigned op);   return op inside {2, 4, 6};    endfunction
    function automatic bit m_wacc(input int unsigned op); return op inside {[2:7]};       endfunction
    function automatic bit m_legal(input int unsigned op); return op <= 10;               endfunction
    function automatic int unsigned m_sela(input int unsigned op);
        if (op == 2) return 0;
        if (op == 3) return 1;
        return 2;
    endfunction
    function automatic bit m_target(input int unsigned op, input bit z);
        if (op == 8)  return z;
        if (op == 9)  return !z;
        return op == 10;
    endfunction

    task automatic check_counts(input string tag);
        check_eq({tag, ".cnt"}, 32'(InstrCount), retired);
        check_eq({tag, ".cnt_sat"}, 32'(s_InstrCount), (retired > 3) ? 3 : retired);
    endtask

    task automatic check_cycle(input string tag, input bit chk_a, input bit chk_alu,
                               input bit wir, input bit wpc, input bit spc, input bit wacc,
                               input bit wram, input bit rram, input bit hlt, input bit ill,
                               input int unsigned sa, input bit sb, input bit sub);
        check_eq({tag, ".WrIR"}, 32'(WrIR), 32'(wir));
        check_eq({tag, ".WrPC"}, 32'(WrPC), 32'(wpc));
        check_eq({tag, ".SelPC"}, 32'(SelPC), 32'(spc));
        check_eq({tag, ".WrAcc"}, 32'(WrAcc), 32'(wacc));
        check_eq({tag, ".WrRam"}, 32'(WrRam), 32'(wram));
        check_eq({tag, ".RdRam"}, 32'(RdRam), 32'(rram));
        check_eq({tag, ".Halted"}, 32'(Halted), 32'(hlt));
        check_eq({tag, ".IllegalOp"}, 32'(IllegalOp), 32'(ill));
        if (chk_a) check_eq({tag, ".SelA"}, 32'(SelA), sa);
        if (chk_alu) begin
            check_eq({tag, ".SelB"}, 32'(SelB), 32'(sb));
            check_eq({tag, ".Op"}, 32'(Op), 32'(sub));
        end
    endtask

    task automatic idle_cycle(input bit st);
        @(negedge Clk);
        Reset = 1'b0; Start = st;
        Opcode = 5'($urandom); Zero = 1'($urandom); RamAck = 1'($urandom);
        #1 check_cycle("idle", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_counts("idle");
    endtask

    // One instruction: FETCH, EXEC, then nwait stall cycles for memory ops.
    task automatic run_instr(input int unsigned op, input bit z, input int unsigned nwait);
        int unsigned nw;
        bit          a_ok, alu_ok, fin;
        nw     = m_mem(op) ? nwait : 0;
        a_ok   = op inside {[2:7]};
        alu_ok = op inside {[4:7]};
        @(negedge Clk);
        Opcode = op[4:0]; Start = 1'($urandom); Zero = 1'($urandom); RamAck = 1'($urandom);
        #1 check_cycle("fetch", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_counts("fetch");
        @(negedge Clk);
        Opcode = 5'($urandom); Start = 1'($urandom); Zero = z;
        RamAck = m_mem(op) ? (nw == 0) : 1'($urandom);
        fin = (op != 0) && (nw == 0);
        #1 check_cycle($sformatf("exec%0d", op), a_ok, alu_ok, 0, fin, fin && m_target(op, z),
                       fin && m_wacc(op), op == 1, m_rd(op), 0, !m_legal(op),
                       m_sela(op), op inside {5, 7}, op inside {6, 7});
        for (int w = 1; w <= int'(nw); w++) begin
            @(negedge Clk);
            RamAck = (w == int'(nw)); Zero = 1'($urandom); Start = 1'($urandom); Opcode = 5'($urandom);
            #1 check_cycle($sformatf("wait%0d", op), a_ok, alu_ok, 0, w == int'(nw), 0,
                           (w == int'(nw)) && m_wacc(op), op == 1, m_rd(op), 0, 0,
                           m_sela(op), op inside {5, 7}, op inside {6, 7});
        end
        if (op != 0) retired++;
    endtask

    task automatic halt_wait(input int unsigned k);
        for (int i = 0; i <= int'(k); i++) begin
            @(negedge Clk);
            Start = (i == int'(k)); Opcode = 5'($urandom); Zero = 1'($urandom); RamAck = 1'($urandom);
            #1 check_cycle("halt", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            check_counts("halt");
        end
    endtask

    initial begin
        int unsigned op, r;
        Reset = 1'b1; Start = 1'b0; Opcode = '0; Zero = 1'b0; RamAck = 1'b0;
        repeat (2) @(negedge Clk);
        #1 check_cycle("reset", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_counts("reset");

        idle_cycle(0); idle_cycle(0); idle_cycle(1);
        run_instr(3, 0, 0);            // LDI
        run_instr(5, 0, 0);            // ADDI
        run_instr(2, 0, 3);            // LD, three stall cycles
        run_instr(8, 1, 0);            // BEQ taken
        run_instr(8, 0, 0);            // BEQ not taken
        run_instr(9, 0, 0);            // BNE taken
        run_instr(10, 0, 0);           // JMP
        run_instr(31, 0, 0);           // illegal
        run_instr(1, 0, 2);            // STO with stalls
        run_instr(0, 0, 0);            // HLT
        halt_wait(2);

        // Reset while stalled in WAIT with RamAck arriving: reset must win.
        @(negedge Clk);
        Start = 1'b0; Opcode = 5'd2; RamAck = 1'($urandom);
        #1 check_eq("rstwait.fetch_WrIR", 32'(WrIR), 1);
        @(negedge Clk);
        RamAck = 1'b0;
        #1 check_eq("rstwait.exec_RdRam", 32'(RdRam), 1);
        @(negedge Clk);
        RamAck = 1'b0;
        #1 check_eq("rstwait.wait_RdRam", 32'(RdRam), 1);
        check_eq("rstwait.wait_WrPC", 32'(WrPC), 0);
        @(negedge Clk);
        Reset = 1'b1; RamAck = 1'b1;
        retired = 0;
        idle_cycle(0);
        idle_cycle(1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 21);
            op = (r <= 10) ? r : ((r <= 19) ? $urandom_range(1, 10) : $urandom_range(11, 31));
            run_instr(op, 1'($urandom), $urandom_range(0, 3));
            if (op == 0) halt_wait($urandom_range(0, 2));
        end

        @(negedge Clk);
        #1 check_counts("final");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
